// File: rtl/status_register_unit.sv
`default_nettype none
// ============================================================================
// Module   : status_register_unit
// Purpose  : Producer side of the condition-flag path. Computes N/Z/C/V from
//            the EXE-stage operands and command, and commits them to the
//            architectural status register on flag-setting instructions.
//            Also provides a combinational hazard for the ID-stage condition
//            checker and a saturating count of committed flag writes.
// Ports    : clk, rst (async, active-high)
//            freeze      - pipeline stall, holds all state
//            flush       - squashes the EXE instruction, blocks its commit
//            valid_in    - EXE holds a real instruction
//            s_in        - instruction sets flags
//            exe_cmd     - 4-bit EXE command
//            val1, val2  - operands (Rn, shifted operand)
//            stat_reg    - committed flags {Z, C, N, V}
//            flag_hazard - flag write pending in EXE (combinational)
//            upd_count   - saturating count of committed flag writes
// Revision : 1.0 - initial release
// ============================================================================
module status_register_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic                 s_in,
    input  logic [3:0]           exe_cmd,
    input  logic [WIDTH-1:0]     val1,
    input  logic [WIDTH-1:0]     val2,
    output logic [3:0]           stat_reg,
    output logic                 flag_hazard,
    output logic [CNT_WIDTH-1:0] upd_count
);

    localparam logic [3:0] c_CMD_MOV = 4'b0001;
    localparam logic [3:0] c_CMD_MVN = 4'b1001;
    localparam logic [3:0] c_CMD_ADD = 4'b0010;
    localparam logic [3:0] c_CMD_ADC = 4'b0011;
    localparam logic [3:0] c_CMD_SUB = 4'b0100;
    localparam logic [3:0] c_CMD_SBC = 4'b0101;
    localparam logic [3:0] c_CMD_AND = 4'b0110;
    localparam logic [3:0] c_CMD_ORR = 4'b0111;
    localparam logic [3:0] c_CMD_EOR = 4'b1000;

    // Committed flags and counter
    logic [3:0]           stat_q;
    logic [3:0]           stat_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Flag computation
    logic [WIDTH:0]       w_alu;
    logic                 w_c_new;
    logic                 w_v_new;
    logic                 w_n_new;
    logic                 w_z_new;
    logic                 w_legal;
    logic                 w_commit;
    logic                 w_cin;
    logic                 w_msb1;
    logic                 w_msb2;
    logic                 w_msbr;

    assign w_cin  = stat_q[2];
    assign w_msb1 = val1[WIDTH-1];
    assign w_msb2 = val2[WIDTH-1];
    assign w_msbr = w_alu[WIDTH-1];

    always_comb begin
        w_alu   = '0;
        w_c_new = stat_q[2];
        w_v_new = stat_q[0];
        w_legal = 1'b1;
        case (exe_cmd)
            c_CMD_ADD, c_CMD_ADC: begin
                w_alu = {1'b0, val1} + {1'b0, val2}
                      + {{WIDTH{1'b0}}, (exe_cmd == c_CMD_ADC) & w_cin};
                w_c_new = w_alu[WIDTH];
                w_v_new = (w_msb1 == w_msb2) && (w_msbr != w_msb1);
            end
            c_CMD_SUB, c_CMD_SBC: begin
                // Bit WIDTH of the extended difference is the borrow; C is its inverse.
                w_alu = {1'b0, val1} - {1'b0, val2}
                      - {{WIDTH{1'b0}}, (exe_cmd == c_CMD_SBC) & ~w_cin};
                w_c_new = ~w_alu[WIDTH];
                w_v_new = (w_msb1 != w_msb2) && (w_msbr != w_msb1);
            end
            c_CMD_MOV: w_alu = {1'b0, val2};
            c_CMD_MVN: w_alu = {1'b0, ~val2};
            c_CMD_AND: w_alu = {1'b0, val1 & val2};
            c_CMD_ORR: w_alu = {1'b0, val1 | val2};
            c_CMD_EOR: w_alu = {1'b0, val1 ^ val2};
            default:   w_legal = 1'b0;
        endcase
    end

    assign w_n_new = w_alu[WIDTH-1];
    assign w_z_new = (w_alu[WIDTH-1:0] == '0);

    // Freeze keeps the hazard up so the instruction retries once the stall lifts.
    assign flag_hazard = valid_in & s_in & ~flush;
    assign w_commit    = flag_hazard & ~freeze & w_legal;

    always_comb begin
        stat_d = stat_q;
        cnt_d  = cnt_q;
        if (w_commit) begin
            stat_d = {w_z_new, w_c_new, w_n_new, w_v_new};
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= 4'b0000;
            cnt_q  <= '0;
        end else begin
            stat_q <= stat_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stat_reg  = stat_q;
    assign upd_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_status_register_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_register_unit
// Purpose  : Scoreboard bench for status_register_unit. A driver issues one
//            instruction per cycle and pushes the reference model's expected
//            hazard/flags/count; a monitor pops and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_register_unit;

    localparam int W    = 32;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic          valid_in = 1'b0;
    logic          s_in = 1'b0;
    logic [3:0]    exe_cmd = 4'd0;
    logic [W-1:0]  val1 = '0;
    logic [W-1:0]  val2 = '0;
    logic [3:0]    stat_reg;
    logic          flag_hazard;
    logic [CW-1:0] upd_count;

    status_register_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .valid_in    (valid_in),
        .s_in        (s_in),
        .exe_cmd     (exe_cmd),
        .val1        (val1),
        .val2        (val2),
        .stat_reg    (stat_reg),
        .flag_hazard (flag_hazard),
        .upd_count   (upd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hz;
        logic [3:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference architectural state
    logic [3:0] m_st  = 4'b0000;
    int         m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Returns {legal, Z, C, N, V} computed with wide integer arithmetic.
    function automatic logic [4:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] st);
        logic            c;
        logic            v;
        logic            lg;
        logic            ci;
        logic [31:0]     r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned us;
        longint          sa;
        longint          sb;
        longint          ss;
        c  = st[2];
        v  = st[0];
        lg = 1'b1;
        r  = '0;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (cmd)
            4'd2, 4'd3: begin
                ci = (cmd == 4'd3) ? st[2] : 1'b0;
                us = ua + ub + 64'(ci);
                r  = us[31:0];
                c  = us[32];
                ss = sa + sb + longint'(ci);
                v  = (ss > SMAX) || (ss < SMIN);
            end
            4'd4, 4'd5: begin
                ci = (cmd == 4'd5) ? ~st[2] : 1'b0;
                c  = ua >= (ub + 64'(ci));
                r  = a - b - 32'(ci);
                ss = sa - sb - longint'(ci);
                v  = (ss > SMAX) || (ss < SMIN);
            end
            4'd1:    r = b;
            4'd9:    r = ~b;
            4'd6:    r = a & b;
            4'd7:    r = a | b;
            4'd8:    r = a ^ b;
            default: lg = 1'b0;
        endcase
        return {lg, (r == 32'd0), c, r[31], v};
    endfunction

    task automatic step(input logic r, input logic vld, input logic s, input logic fl,
                        input logic fz, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b);
        logic [4:0] res;
        logic       hz;
        exp_t       e;
        @(negedge clk);
        rst = r; valid_in = vld; s_in = s; flush = fl; freeze = fz;
        exe_cmd = cmd; val1 = a; val2 = b;
        res = model(cmd, a, b, m_st);
        hz  = vld & s & ~fl;
        if (r) begin
            m_st  = 4'b0000;
            m_cnt = 0;
        end else if (hz && !fz && res[4]) begin
            m_st = res[3:0];
            if (m_cnt != CMAX) m_cnt++;
        end
        e.hz  = hz;
        e.st  = m_st;
        e.cnt = CW'(m_cnt);
        q.push_back(e);
    endtask

    // Immediate check of the DUT state just after the coming clock edge.
    task automatic now_chk(input string name, input logic [3:0] st, input int cnt);
        @(posedge clk);
        #2;
        chk({name, "_stat"}, 32'(stat_reg), 32'(st));
        chk({name, "_cnt"}, 32'(upd_count), 32'(cnt));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: one expectation per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hazard", 32'(flag_hazard), 32'(e.hz));
                #1;
                chk("stat_reg", 32'(stat_reg), 32'(e.st));
                chk("upd_count", 32'(upd_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        int guard;
        #1 rst = 1'b1;
        #1;
        chk("reset_stat", 32'(stat_reg), 32'd0);
        chk("reset_cnt", 32'(upd_count), 32'd0);

        step(1, 0, 0, 0, 0, 4'd0, 0, 0);
        // ADD overflow into sign bit
        step(0, 1, 1, 0, 0, 4'd2, 32'h7FFF_FFFF, 32'h1);
        now_chk("tp_add", 4'b0011, 1);
        // CMP equal, then AND giving zero
        step(0, 1, 1, 0, 0, 4'd4, 32'd5, 32'd5);
        now_chk("tp_cmp", 4'b1100, 2);
        step(0, 1, 1, 0, 0, 4'd6, 32'hF0, 32'h0F);
        now_chk("tp_and", 4'b1100, 3);
        // Flushed ADD
        step(0, 1, 1, 1, 0, 4'd2, 32'h7FFF_FFFF, 32'h1);
        now_chk("tp_flush", 4'b1100, 3);
        // Frozen ADD for three cycles, then commits
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 4'd2, 32'h7FFF_FFFF, 32'h1);
        step(0, 1, 1, 0, 0, 4'd2, 32'h7FFF_FFFF, 32'h1);
        now_chk("tp_unfreeze", 4'b0011, 4);
        // Illegal command with S set
        step(0, 1, 1, 0, 0, 4'd15, 32'h0, 32'h0);
        now_chk("tp_illegal", 4'b0011, 4);
        // ADC chain using carry from the previous edge
        step(0, 1, 1, 0, 0, 4'd2, 32'hFFFF_FFFF, 32'h1);
        step(0, 1, 1, 0, 0, 4'd3, 32'h0, 32'h0);
        now_chk("tp_adc", 4'b0000, 6);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)), pick(), pick());
        end

        // Reset coinciding with a committing SUB
        step(1, 1, 1, 0, 0, 4'd4, 32'd5, 32'd5);
        now_chk("tp_rst_sub", 4'b0000, 0);
        // Saturate the counter
        for (int i = 0; i < CMAX + 4; i++) step(0, 1, 1, 0, 0, 4'd1, 32'h0, 32'd5);
        now_chk("tp_sat", 4'b0000, CMAX);

        @(negedge clk);
        valid_in = 1'b0; s_in = 1'b0; rst = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
